// File: rtl/mem_responder.sv
// Responder for the byte-wide CPU memory bus: byte RAM with 1-cycle read latency plus an IO
// window feeding a TX byte FIFO. Optional MEM_BOUNDS_CHECK_EN flags out-of-range RAM accesses.
module mem_responder #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_w_data,
  output logic [7:0]  mem_r_data,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  output logic        io_full,
  output logic        err_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    ram_mem_r [2**ADDR_W];
  logic [7:0]    ram_q_r;
  logic [7:0]    io_q_r;
  logic          rd_src_r;
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          valid_r;
  logic          full_r;
  logic [7:0]    ovf_r;
  logic          err_r;

  logic          is_io_s;
  logic          oob_s;
  logic          ram_we_s;
  logic          ram_re_s;
  logic          push_req_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [7:0]    cnt_disp_s;
  logic [7:0]    io_rd_s;
  logic          unused_s;

  assign is_io_s = (mem_addr[17:16] == 2'b11);

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_s = !is_io_s && (mem_addr[31:ADDR_W] != {(32-ADDR_W){1'b0}});
`else
  assign oob_s = 1'b0;
`endif

  assign unused_s   = ^mem_addr;
  assign ram_we_s   = rdy_in &  mem_wr & !is_io_s & !oob_s;
  assign ram_re_s   = rdy_in & !mem_wr & !is_io_s & !oob_s;
  assign push_req_s = rdy_in &  mem_wr &  is_io_s & (mem_addr[15:0] == 16'h0000);
  assign pop_s      = valid_r & io_tx_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_s     = push_req_s & (!full_r | pop_s);
  assign drop_s     = push_req_s & full_r & !pop_s;

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Non-RAM read value: IO registers, or the out-of-range marker.
  always_comb begin
    io_rd_s    = 8'h00;
    cnt_disp_s = (32'(count_r) > 32'd255) ? 8'hFF : 8'(count_r);
    if (oob_s) begin
      io_rd_s = 8'hFF;
    end else if (is_io_s) begin
      case (mem_addr[15:0])
        16'h0004: io_rd_s = cnt_disp_s;
        16'h0008: io_rd_s = ovf_r;
        default:  io_rd_s = 8'h00;
      endcase
    end else begin
      io_rd_s = 8'h00;
    end
  end

  // RAM array with synchronous read port; contents are never reset.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_mem_r[mem_addr[ADDR_W-1:0]] <= mem_w_data;
    end
    if (ram_re_s) begin
      ram_q_r <= ram_mem_r[mem_addr[ADDR_W-1:0]];
    end
  end

  // Read-source select and IO read capture; both hold on writes and when frozen.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_src_r <= 1'b0;
      io_q_r   <= 8'h00;
    end else if (rdy_in && !mem_wr) begin
      rd_src_r <= ram_re_s;
      io_q_r   <= io_rd_s;
    end
  end

  assign mem_r_data = rd_src_r ? ram_q_r : io_q_r;

  // FIFO storage; stale entries after reset are unreachable because pointers reset.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mem_w_data;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      full_r  <= (count_nxt_s == CW'(FIFO_DEPTH));
    end
  end

  // Saturating drop counter and sticky range error.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ovf_r <= 8'h00;
      err_r <= 1'b0;
    end else begin
      if (drop_s && (ovf_r != 8'hFF)) ovf_r <= ovf_r + 8'd1;
      if (rdy_in && oob_s) err_r <= 1'b1;
    end
  end

  assign io_tx_valid = valid_r;
  assign io_tx_data  = valid_r ? fifo_mem_r[rd_ptr_r] : 8'h00;
  assign io_full     = full_r;
  assign err_out     = err_r;

endmodule
